// File: rtl/regbank_dump_if.sv
// Dump stream between regbank_dump (master) and its trace sink (slave).
// REGBANK_DUMP_CKSUM_EN adds the checksum-beat flag.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface regbank_dump_if #(
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH
);
    logic                  dump_valid_out;
    logic                  dump_ready_in;
    logic [DATA_WIDTH-1:0] dump_data_out;
    logic [4:0]            dump_index_out;
    logic                  dump_last_out;
`ifdef REGBANK_DUMP_CKSUM_EN
    logic                  dump_is_cksum_out;
`endif

    modport master (
`ifdef REGBANK_DUMP_CKSUM_EN
        output dump_is_cksum_out,
`endif
        output dump_valid_out,
        output dump_data_out,
        output dump_index_out,
        output dump_last_out,
        input  dump_ready_in
    );

    modport slave (
`ifdef REGBANK_DUMP_CKSUM_EN
        input  dump_is_cksum_out,
`endif
        input  dump_valid_out,
        input  dump_data_out,
        input  dump_index_out,
        input  dump_last_out,
        output dump_ready_in
    );
endinterface

// File: rtl/regbank_dump.sv
// Walks register indices FIRST_REG..LAST_REG on the bank read port and streams each word out.
// REGBANK_DUMP_CKSUM_EN appends a final XOR-checksum beat.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module regbank_dump #(
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned FIRST_REG  = 0,
    parameter int unsigned LAST_REG   = 31
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  start_in,
    output logic [4:0]            rd_addr_out,
    input  logic [DATA_WIDTH-1:0] rd_data_in,
    output logic                  busy_out,
    output logic                  done_out,
    regbank_dump_if.master        dump
);
    localparam logic [4:0] FirstIdx = 5'(FIRST_REG);
    localparam logic [4:0] LastIdx  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StSend,
        StCksum
    } state_e;

    state_e                r_state, w_state;
    logic [4:0]            r_rd_addr, w_rd_addr;
    logic                  r_busy, w_busy;
    logic                  r_done, w_done;
    logic                  r_valid, w_valid;
    logic [DATA_WIDTH-1:0] r_data, w_data;
    logic [4:0]            r_index, w_index;
    logic                  r_last, w_last;
`ifdef REGBANK_DUMP_CKSUM_EN
    logic [DATA_WIDTH-1:0] r_cksum, w_cksum;
    logic                  r_is_cksum, w_is_cksum;
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_rd_addr  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_index    <= '0;
            r_last     <= 1'b0;
`ifdef REGBANK_DUMP_CKSUM_EN
            r_cksum    <= '0;
            r_is_cksum <= 1'b0;
`endif
        end else begin
            r_state    <= w_state;
            r_rd_addr  <= w_rd_addr;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_valid    <= w_valid;
            r_data     <= w_data;
            r_index    <= w_index;
            r_last     <= w_last;
`ifdef REGBANK_DUMP_CKSUM_EN
            r_cksum    <= w_cksum;
            r_is_cksum <= w_is_cksum;
`endif
        end
    end

    always_comb begin
        w_state   = r_state;
        w_rd_addr = r_rd_addr;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_valid   = r_valid;
        w_data    = r_data;
        w_index   = r_index;
        w_last    = r_last;
`ifdef REGBANK_DUMP_CKSUM_EN
        w_cksum    = r_cksum;
        w_is_cksum = r_is_cksum;
`endif

        unique case (r_state)
            StIdle: begin
                if (start_in) begin
                    w_rd_addr = FirstIdx;
                    w_busy    = 1'b1;
                    w_state   = StFetch;
`ifdef REGBANK_DUMP_CKSUM_EN
                    w_cksum   = '0;
`endif
                end
            end

            StFetch: begin
                w_data  = rd_data_in;
                w_index = r_rd_addr;
                w_valid = 1'b1;
                w_state = StSend;
`ifdef REGBANK_DUMP_CKSUM_EN
                // Last flag belongs to the checksum beat only.
                w_last     = 1'b0;
                w_is_cksum = 1'b0;
                w_cksum    = r_cksum ^ rd_data_in;
`else
                w_last  = (r_rd_addr == LastIdx);
`endif
            end

            StSend: begin
                if (r_valid && dump.dump_ready_in) begin
                    w_valid = 1'b0;
                    if (r_index != LastIdx) begin
                        w_rd_addr = r_rd_addr + 5'd1;
                        w_state   = StFetch;
                    end else begin
`ifdef REGBANK_DUMP_CKSUM_EN
                        if (r_is_cksum) begin
                            w_busy  = 1'b0;
                            w_done  = 1'b1;
                            w_state = StIdle;
                        end else begin
                            w_state = StCksum;
                        end
`else
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_state = StIdle;
`endif
                    end
                end
            end

            StCksum: begin
`ifdef REGBANK_DUMP_CKSUM_EN
                w_data     = r_cksum;
                w_index    = LastIdx;
                w_last     = 1'b1;
                w_is_cksum = 1'b1;
                w_valid    = 1'b1;
                w_state    = StSend;
`else
                w_state    = StIdle;
`endif
            end

            default: w_state = StIdle;
        endcase
    end

    assign rd_addr_out         = r_rd_addr;
    assign busy_out            = r_busy;
    assign done_out            = r_done;
    assign dump.dump_valid_out = r_valid;
    assign dump.dump_data_out  = r_data;
    assign dump.dump_index_out = r_index;
    assign dump.dump_last_out  = r_last;
`ifdef REGBANK_DUMP_CKSUM_EN
    assign dump.dump_is_cksum_out = r_is_cksum;
`endif
endmodule

// File: tb/tb_regbank_dump.sv
// Directed bench for regbank_dump: a full 0..31 instance and a 3..6 instance share one bank model.
module tb_regbank_dump;
    localparam int unsigned DW = 32;
`ifdef REGBANK_DUMP_CKSUM_EN
    localparam bit CKSUM = 1'b1;
`else
    localparam bit CKSUM = 1'b0;
`endif
    localparam int DONE_FULL = CKSUM ? 66 : 64;
    localparam int DONE_SUB  = CKSUM ? 10 : 8;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
        logic        cks;
    } beat_t;

    typedef struct {
        string name;
        bit    use_sub;
        int    stall_idx;
        int    stall_n;
        int    start_at;
        int    exp_done_at;
    } scen_t;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        rst_n, start, ready, sel;
    logic [31:0] bank [32];
    logic [4:0]  addr_full, addr_sub;
    logic        busy_full, done_full, busy_sub, done_sub;
    logic        start_full, start_sub;
    logic [31:0] rd_full, rd_sub;

    regbank_dump_if #(.DATA_WIDTH(DW)) if_full ();
    regbank_dump_if #(.DATA_WIDTH(DW)) if_sub ();

    assign if_full.dump_ready_in = ready;
    assign if_sub.dump_ready_in  = ready;
    assign start_full = start & ~sel;
    assign start_sub  = start & sel;
    assign rd_full    = bank[addr_full];
    assign rd_sub     = bank[addr_sub];

    regbank_dump #(.DATA_WIDTH(DW), .FIRST_REG(0), .LAST_REG(31)) u_full (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .start_in    (start_full),
        .rd_addr_out (addr_full),
        .rd_data_in  (rd_full),
        .busy_out    (busy_full),
        .done_out    (done_full),
        .dump        (if_full)
    );

    regbank_dump #(.DATA_WIDTH(DW), .FIRST_REG(3), .LAST_REG(6)) u_sub (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .start_in    (start_sub),
        .rd_addr_out (addr_sub),
        .rd_data_in  (rd_sub),
        .busy_out    (busy_sub),
        .done_out    (done_sub),
        .dump        (if_sub)
    );

    // View of whichever instance is selected.
    logic        w_valid, w_last, w_cks, w_busy, w_done;
    logic [4:0]  w_idx, w_addr;
    logic [31:0] w_data;
    always_comb begin
        w_cks = 1'b0;
        if (sel) begin
            w_valid = if_sub.dump_valid_out;
            w_last  = if_sub.dump_last_out;
            w_idx   = if_sub.dump_index_out;
            w_data  = if_sub.dump_data_out;
            w_busy  = busy_sub;
            w_done  = done_sub;
            w_addr  = addr_sub;
`ifdef REGBANK_DUMP_CKSUM_EN
            w_cks   = if_sub.dump_is_cksum_out;
`endif
        end else begin
            w_valid = if_full.dump_valid_out;
            w_last  = if_full.dump_last_out;
            w_idx   = if_full.dump_index_out;
            w_data  = if_full.dump_data_out;
            w_busy  = busy_full;
            w_done  = done_full;
            w_addr  = addr_full;
`ifdef REGBANK_DUMP_CKSUM_EN
            w_cks   = if_full.dump_is_cksum_out;
`endif
        end
    end

    int    n_cmp = 0;
    int    n_bad = 0;
    beat_t got [$];
    beat_t exp_full [$];
    beat_t exp_sub [$];
    scen_t scen [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input int idx, input logic [31:0] data, input bit last,
                                 input bit cks);
        beat_t b;
        b.idx  = 5'(idx);
        b.data = data;
        b.last = last;
        b.cks  = cks;
        return b;
    endfunction

    // Starts a dump on the selected instance and records every accepted beat.
    task automatic run_dump(input bit use_sub, input int stall_idx, input int stall_n,
                            input int start_at, output int done_at, output int hold_bad);
        int    stalls = 0;
        beat_t snap, cur;
        snap = '0;
        got.delete();
        done_at  = -1;
        hold_bad = 0;
        sel   = use_sub;
        ready = 1'b1;
        @(negedge clk_in);
        start = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk_in);
            start    = (cyc == start_at);
            cur.idx  = w_idx;
            cur.data = w_data;
            cur.last = w_last;
            cur.cks  = w_cks;
            if (w_valid && int'(w_idx) == stall_idx && !w_cks && stalls < stall_n) begin
                if (stalls == 0) snap = cur;
                else if (cur != snap) hold_bad++;
                stalls++;
                ready = 1'b0;
            end else begin
                ready = 1'b1;
            end
            if (w_valid && ready) got.push_back(cur);
            if (w_done) begin
                done_at = cyc;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic compare_beats(input string tag, input beat_t exp[$]);
        check({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), 64'(got[i]), 64'(exp[i]));
    endtask

    int done_at, hold_bad, found, ndone;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        sel   = 1'b0;
        for (int i = 0; i < 32; i++) bank[i] = 32'h0;
        bank[3] = 32'h5555_5555;
        bank[6] = 32'hAAAA_AAAA;

        for (int i = 0; i < 32; i++)
            exp_full.push_back(mk(i, (i == 3) ? 32'h5555_5555 : (i == 6) ? 32'hAAAA_AAAA : 32'h0,
                                  !CKSUM && i == 31, 1'b0));
        exp_sub.push_back(mk(3, 32'h5555_5555, 1'b0, 1'b0));
        exp_sub.push_back(mk(4, 32'h0, 1'b0, 1'b0));
        exp_sub.push_back(mk(5, 32'h0, 1'b0, 1'b0));
        exp_sub.push_back(mk(6, 32'hAAAA_AAAA, !CKSUM, 1'b0));
        if (CKSUM) begin
            exp_full.push_back(mk(31, 32'hFFFF_FFFF, 1'b1, 1'b1));
            exp_sub.push_back(mk(6, 32'hFFFF_FFFF, 1'b1, 1'b1));
        end

        //            name          sub   stall_idx stall_n start_at done_at
        scen[0] = '{"sub3to6",     1'b1, -1,       0,      -1,      DONE_SUB};
        scen[1] = '{"stall6",      1'b0, 6,        3,      -1,      DONE_FULL + 3};
        scen[2] = '{"midstart",    1'b0, -1,       0,      20,      DONE_FULL};
        scen[3] = '{"full",        1'b0, -1,       0,      -1,      DONE_FULL};

        repeat (2) @(negedge clk_in);
        check("rst_busy",  64'(busy_full), 64'(0));
        check("rst_done",  64'(done_full), 64'(0));
        check("rst_valid", 64'(if_full.dump_valid_out), 64'(0));
        check("rst_addr",  64'(addr_full), 64'(0));
        check("rst_data",  64'(if_full.dump_data_out), 64'(0));
        check("rst_index", 64'(if_full.dump_index_out), 64'(0));
        check("rst_last",  64'(if_full.dump_last_out), 64'(0));
        rst_n = 1'b1;

        for (int s = 0; s < 4; s++) begin
            run_dump(scen[s].use_sub, scen[s].stall_idx, scen[s].stall_n, scen[s].start_at,
                     done_at, hold_bad);
            compare_beats(scen[s].name, scen[s].use_sub ? exp_sub : exp_full);
            check({scen[s].name, "_done_at"}, 64'(done_at), 64'(scen[s].exp_done_at));
            check({scen[s].name, "_hold"}, 64'(hold_bad), 64'(0));
            if (s < 3) begin
                @(negedge clk_in);
                check({scen[s].name, "_done_pulse"}, 64'(w_done), 64'(0));
                check({scen[s].name, "_busy_after"}, 64'(w_busy), 64'(0));
            end
        end

        // Start on the edge where done falls.
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        check("b2b_done_low", 64'(w_done), 64'(0));
        check("b2b_busy", 64'(w_busy), 64'(1));
        check("b2b_addr", 64'(w_addr), 64'(0));

        // Asynchronous reset while beat 10 is presented.
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            if (w_valid && w_idx == 5'd10) begin
                found = 1;
                break;
            end
        end
        check("beat10_reached", 64'(found), 64'(1));
        rst_n = 1'b0;
        #1;
        check("arst_busy",  64'(w_busy), 64'(0));
        check("arst_valid", 64'(w_valid), 64'(0));
        check("arst_index", 64'(w_idx), 64'(0));
        check("arst_addr",  64'(w_addr), 64'(0));
        check("arst_done",  64'(w_done), 64'(0));
        @(negedge clk_in);
        rst_n = 1'b1;
        ndone = 0;
        repeat (70) begin
            @(negedge clk_in);
            if (w_done || w_busy || w_valid) ndone++;
        end
        check("arst_stays_idle", 64'(ndone), 64'(0));

        run_dump(1'b0, -1, 0, -1, done_at, hold_bad);
        compare_beats("after_rst", exp_full);
        check("after_rst_done_at", 64'(done_at), 64'(DONE_FULL));
        @(negedge clk_in);
        check("after_rst_busy", 64'(w_busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regbank_dump.md
# regbank_dump

Read-side sequencer for the register bank: on a start pulse it walks a contiguous range of register indices and drives each index onto a regbank read-address port. It captures the asynchronous read data and streams each word out over a valid/ready handshake with its index. The block sits beside `regbank`, driving `srcA` or `srcB`, and feeds a debug/trace sink or a self-checking bench. It never writes the bank.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32): register word width.
- `FIRST_REG`, default 0: first index dumped.
- `LAST_REG`, default 31: last index dumped. Requires `FIRST_REG <= LAST_REG <= 31`.

Ports:
- `clk_in`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_in`  in  1  request a dump; sampled only in IDLE.
- `rd_addr_out`  out  5  read index to regbank `srcA`/`srcB`.
- `rd_data_in`  in  DATA_WIDTH  combinational read data from regbank for `rd_addr_out`.
- `busy_out`  out  1  high from the start acceptance through the final handshake.
- `done_out`  out  1  one-cycle pulse after the final beat is accepted.
- `dump_valid_out`  out  1  a beat is presented.
- `dump_ready_in`  in  1  the sink accepts the beat.
- `dump_data_out`  out  DATA_WIDTH  captured register word.
- `dump_index_out`  out  5  index of `dump_data_out`.
- `dump_last_out`  out  1  the current beat is the final one.
- `dump_is_cksum_out`  out  1  present only with `REGBANK_DUMP_CKSUM_EN`; see Configuration.

## Operation
- States: IDLE, FETCH, SEND, plus CKSUM (macro only).
- Reset (async, any state): state goes to IDLE. All outputs are 0, including `rd_addr_out`, `dump_data_out` and `dump_index_out`. Any dump in progress is abandoned and no `done_out` is issued.
- IDLE: on a clock edge with `start_in=1`:
  - `rd_addr_out <= FIRST_REG`, `busy_out <= 1`, state goes to FETCH.
  - `start_in` is ignored in every other state.
- FETCH: on the next edge:
  - `dump_data_out <= rd_data_in`, `dump_index_out <= rd_addr_out`.
  - `dump_valid_out <= 1`.
  - `dump_last_out <= (rd_addr_out == LAST_REG)`, forced to 0 when the macro is defined.
  - State goes to SEND.
- SEND, while `dump_valid_out && !dump_ready_in`: data, index, last and valid hold stable.
- SEND, at the handshake edge (`valid && ready`):
  - Index not equal to `LAST_REG`: `rd_addr_out` increments, valid goes to 0, state goes to FETCH.
  - Index equals `LAST_REG`, macro undefined: valid goes to 0, `busy_out` goes to 0, `done_out` goes to 1 for one cycle, state goes to IDLE.
  - Index equals `LAST_REG`, macro defined: state goes to CKSUM (see Configuration).
- `rd_addr_out` is not incremented past `LAST_REG`, so the index never wraps.
- `rd_data_in` is passed through unmodified; x0 reads as whatever the bank returns.
- `dump_ready_in` while valid is low has no effect.

## Timing
- Let E0 be the edge at which start is accepted.
- Valid first rises at E1.
- With ready held high, beat k is accepted at E(2+2k). Throughput is one beat per 2 cycles.
- Full 0..31 dump: last handshake at E64; `done_out` is high during the cycle after E64.
- Each beat's `rd_data_in` is sampled exactly one cycle after `rd_addr_out` changes.
- A write to the bank landing at the FETCH edge shows its pre-write value; regbank write-through behaviour governs this.
- `start_in` high on the same edge that `done_out` falls is accepted (IDLE already entered).

## Configuration
- `REGBANK_DUMP_CKSUM_EN` defined:
  - A running XOR of all captured words is kept and cleared at start acceptance.
  - After the `LAST_REG` handshake, one extra beat is presented: data is the XOR, index equals `LAST_REG`, and `dump_is_cksum_out=1`, `dump_last_out=1`.
  - `done_out` follows acceptance of that beat, adding 2 cycles.
- Undefined: no accumulator, no extra beat, and `dump_is_cksum_out` does not exist.

## Test plan
- Bank preloaded: r6=AAAAAAAA, r3=55555555, all others 0; start with ready=1 -> 32 beats, index 0..31, beat 3=55555555, beat 6=AAAAAAAA, last only on index 31, `done_out` in the cycle after E64, `busy_out` low afterward.
- Ready low for 3 cycles while beat 6 is presented -> data AAAAAAAA and index 6 held stable, exactly one transfer, next beat is index 7.
- `FIRST_REG=3`, `LAST_REG=6` -> exactly 4 beats: 55555555, 0, 0, AAAAAAAA; last on index 6.
- `rst_n` low for one cycle during beat 10 -> all outputs 0 immediately, no `done_out`; a new start dumps again from index 0.
- Start pulsed mid-dump -> ignored, beat count unchanged.
- Macro defined with the preload from scenario 1 -> 33rd beat data FFFFFFFF, `dump_is_cksum_out=1`, `dump_last_out=1`; `done_out` 2 cycles later than without the macro.
